return_stack: RTL and testbench

Hardware return-address stack sitting directly downstream of `control_module`. It consumes the `push`/`pop` strobes issued for call and return instructions. On a push it captures the return address from the program-counter path. On a pop it presents the saved address back to the instruction-address mux. It is a parameterised LIFO with a registered top-of-stack, occupancy count, and sticky overflow/underflow error flags for the debug path.

---
 rtl/return_stack.sv | 131 +++++++++++++
 tb/tb_return_stack.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses fed by the call/return strobes of
// control_module. The top of stack is held in its own register, so the
// consumer can read it during the pop cycle. Overflow and underflow flags
// are sticky and go to the debug path.
module return_stack #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] ret_addr_in,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] ret_addr_out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] top_q, top_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      rd_idx;
    logic                  empty_w;
    logic                  full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_WIDTH'(DEPTH));

    // Entry just below the current top. It is only used when count >= 2,
    // so the subtraction never wraps when it matters.
    assign rd_idx = PTR_W'(count_q - CNT_WIDTH'(2));

    // Next-state decode for pointer, top register, flags and array write.
    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        wr_en   = 1'b0;
        wr_idx  = PTR_W'(count_q);
        unique case ({push, pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en   = 1'b1;
                    wr_idx  = PTR_W'(count_q);
                    count_d = count_q + CNT_WIDTH'(1);
                    top_d   = ret_addr_in;
                end else begin
                    // Dropped push: contents stay intact, flag it.
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (empty_w) begin
                    unf_d = 1'b1;
                end else if (count_q == CNT_WIDTH'(1)) begin
                    count_d = '0;
                    top_d   = '0;
                end else begin
                    count_d = count_q - CNT_WIDTH'(1);
                    top_d   = mem_q[rd_idx];
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                top_d = ret_addr_in;
                if (empty_w) begin
                    // Nothing to replace: behaves as a push, but the pop
                    // half had nothing to remove.
                    wr_idx  = '0;
                    count_d = CNT_WIDTH'(1);
                    unf_d   = 1'b1;
                end else begin
                    // Replace the top in place; depth unchanged.
                    wr_idx = PTR_W'(count_q - CNT_WIDTH'(1));
                end
            end
            default: begin
            end
        endcase
    end

    // Control state: pointer, top-of-stack and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage entries carry no reset; slots above the pointer are never read.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Write one entry when it is the selected slot.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_idx == PTR_W'(gi))) begin
                    mem_q[gi] <= ret_addr_in;
                end
            end
        end
    endgenerate

    assign ret_addr_out = top_q;
    assign count        = count_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Testbench for return_stack: each drive pushes the model's expected state to
// a scoreboard and the observed post-edge state to a second queue; each test
// task drains both and compares them inline.
module tb_return_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] ret_addr_in;
    logic       err_clr;
    logic [7:0] ret_addr_out;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    return_stack #(.ADDR_WIDTH(8), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .ret_addr_in  (ret_addr_in),
        .err_clr      (err_clr),
        .ret_addr_out (ret_addr_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] top;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } state_t;

    state_t     sb[$];
    state_t     act_q[$];
    logic [7:0] pre_q[$];

    logic [7:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;

    int errors = 0;
    int checks = 0;

    // Reference behaviour of one clock edge.
    task automatic model_step(input logic p, input logic q, input logic [7:0] d, input logic c);
        state_t e;
        logic n_ovf;
        logic n_unf;
        n_ovf = m_ovf & ~c;
        n_unf = m_unf & ~c;
        if (p && !q) begin
            if (m_stk.size() < 8) m_stk.push_back(d);
            else n_ovf = 1'b1;
        end else if (!p && q) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else n_unf = 1'b1;
        end else if (p && q) begin
            if (m_stk.size() > 0) m_stk[m_stk.size()-1] = d;
            else begin
                m_stk.push_back(d);
                n_unf = 1'b1;
            end
        end
        m_ovf = n_ovf;
        m_unf = n_unf;
        e.top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 8'h00;
        e.cnt = 4'(m_stk.size());
        e.emp = (m_stk.size() == 0);
        e.ful = (m_stk.size() == 8);
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
    endtask

    // Apply one operation for one edge; record pre-edge top and post-edge state.
    task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic c);
        @(negedge clk);
        push = p; pop = q; ret_addr_in = d; err_clr = c;
        model_step(p, q, d, c);
        #1;
        pre_q.push_back(ret_addr_out);
        @(posedge clk);
        #1;
        act_q.push_back({ret_addr_out, count, empty, full, overflow, underflow});
        $display("op push=%b pop=%b clr=%b in=%h -> top=%h cnt=%0d e=%b f=%b o=%b u=%b",
                 p, q, c, d, ret_addr_out, count, empty, full, overflow, underflow);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; push = 1'b0; pop = 1'b0; ret_addr_in = 8'h00; err_clr = 1'b0;
        m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #12;
        checks++;
        if ({ret_addr_out, count, empty, full, overflow, underflow} !== {8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got top=%h cnt=%0d e=%b f=%b o=%b u=%b, want top=00 cnt=0 e=1 f=0 o=0 u=0",
                     ret_addr_out, count, empty, full, overflow, underflow);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_lifo();
        logic [7:0] want_top [6] = '{8'h10, 8'h20, 8'h30, 8'h20, 8'h10, 8'h00};
        logic [3:0] want_cnt [6] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        state_t e, a;
        drive(1, 0, 8'h10, 0);
        drive(1, 0, 8'h20, 0);
        drive(1, 0, 8'h30, 0);
        repeat (3) drive(0, 1, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e || a.top !== want_top[i] || a.cnt !== want_cnt[i]) begin
                errors++;
                $display("FAIL lifo step %0d: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         i, a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, want_top[i], want_cnt[i], e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_overflow();
        state_t e, a;
        for (int i = 1; i <= 9; i++) drive(1, 0, 8'(i), 0);
        checks++;
        if ({full, count, overflow, ret_addr_out} !== {1'b1, 4'd8, 1'b1, 8'h08}) begin
            errors++;
            $display("FAIL overflow_full: got full=%b cnt=%0d ovf=%b top=%h, want full=1 cnt=8 ovf=1 top=08",
                     full, count, overflow, ret_addr_out);
        end
        repeat (8) drive(0, 1, 8'h00, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL overflow step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_underflow();
        state_t e, a;
        drive(0, 0, 8'h00, 1);
        drive(0, 1, 8'h00, 0);
        drive(0, 0, 8'h00, 1);
        drive(0, 1, 8'h00, 1);
        checks++;
        if ({underflow, count} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL underflow_clr_race: got unf=%b cnt=%0d, want unf=1 cnt=0", underflow, count);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL underflow step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_push_pop();
        state_t e, a;
        drive(0, 0, 8'h00, 1);
        drive(1, 0, 8'h11, 0);
        drive(1, 0, 8'h22, 0);
        drive(1, 1, 8'h33, 0);
        checks++;
        if ({count, ret_addr_out} !== {4'd2, 8'h33}) begin
            errors++;
            $display("FAIL replace_top: got cnt=%0d top=%h, want cnt=2 top=33", count, ret_addr_out);
        end
        drive(0, 1, 8'h00, 0);
        drive(0, 1, 8'h00, 0);
        drive(1, 1, 8'h44, 0);
        // Fill, then replace the top while full: no flag may be raised.
        for (int i = 0; i < 7; i++) drive(1, 0, 8'h50 + 8'(i), 0);
        drive(1, 1, 8'hEE, 0);
        repeat (8) drive(0, 1, 8'h00, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL push_pop step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_async_reset();
        state_t e, a;
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) drive(1, 0, 8'hA0 + 8'(i), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        checks++;
        if ({count, ret_addr_out, empty, overflow, underflow} !== {4'd0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d top=%h e=%b o=%b u=%b, want cnt=0 top=00 e=1 o=0 u=0",
                     count, ret_addr_out, empty, overflow, underflow);
        end
        #2 rst = 1'b1;
        $display("async reset pulse done");
        drive(0, 1, 8'h00, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL async step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_integration();
        state_t e, a;
        logic [7:0] ret1, ret2;
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);
        drive(1, 0, 8'h05, 0);   // call from 0x04
        drive(0, 0, 8'h00, 0);
        drive(1, 0, 8'h0A, 0);   // nested call from 0x09
        drive(0, 0, 8'h00, 0);
        pre_q.delete();
        drive(0, 1, 8'h00, 0);   // inner return
        ret1 = pre_q.pop_front();
        drive(0, 0, 8'h00, 0);
        pre_q.delete();
        drive(0, 1, 8'h00, 0);   // outer return
        ret2 = pre_q.pop_front();
        checks++;
        if ({ret1, ret2} !== {8'h0A, 8'h05}) begin
            errors++;
            $display("FAIL integration_returns: got %h,%h, want 0a,05", ret1, ret2);
        end
        checks++;
        if ({empty, overflow, underflow} !== 3'b100) begin
            errors++;
            $display("FAIL integration_end: got e=%b o=%b u=%b, want e=1 o=0 u=0", empty, overflow, underflow);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL integration step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_back_to_back();
        state_t e, a;
        logic [7:0] pre;
        logic [7:0] want_pre;
        logic       p, q, c;
        for (int i = 0; i < 60; i++) begin
            if (i < 20) begin
                p = (i % 2) == 0; q = !p; c = 1'b0;
            end else begin
                p = 1'($urandom_range(0, 1)); q = 1'($urandom_range(0, 1));
                c = ($urandom_range(0, 9) == 0);
            end
            want_pre = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 8'h00;
            drive(p, q, 8'($urandom_range(0, 255)), c);
            pre = pre_q.pop_back();
            checks++;
            if (pre !== want_pre) begin
                errors++;
                $display("FAIL b2b pre_edge_top %0d: got %h, want %h", i, pre, want_pre);
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL b2b step: got top=%h cnt=%0d flags=%b%b%b%b, want top=%h cnt=%0d flags=%b%b%b%b",
                         a.top, a.cnt, a.emp, a.ful, a.ovf, a.unf, e.top, e.cnt, e.emp, e.ful, e.ovf, e.unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_async_reset();
        test_integration();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
